// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM encoding,
// idle/initial nibble patterns and small nibble helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_t;

    localparam logic [3:0] COL_INIT = 4'b1110;
    localparam logic [3:0] ROW_IDLE = 4'b1111;

    // True when exactly one bit of an active-low nibble is 0.
    function automatic logic is_single_low(input logic [3:0] v);
        return (v == 4'b1110) || (v == 4'b1101) ||
               (v == 4'b1011) || (v == 4'b0111);
    endfunction

    function automatic logic [1:0] low_idx(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous 4-bit row bus; resets to the
// idle (all released) pattern so no phantom press follows reset.
module keypad_sync
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_d,
    output logic [3:0] o_q
);

    logic [3:0] r_meta;
    logic [3:0] r_sync;

    // NOTE: non-blocking assignments make both flops sample the old values on
    // the same edge; blocking here would collapse the chain into one stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= ROW_IDLE;
            r_sync <= ROW_IDLE;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column, samples the
// synchronized rows once per slot, and debounces both press and release.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [7:0] key_code,
    output logic [3:0] key_index,
    output logic       key_valid,
    output logic       key_held
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] MATCH_LAST = CW'(DEBOUNCE_CNT - 1);

    logic [3:0]    w_row_sync;
    logic          w_sample;
    logic          w_single;
    logic          w_idle;

    kp_state_t     r_state;
    kp_state_t     w_state_nxt;
    logic [CW-1:0] w_match_nxt;
    logic          w_capture;
    logic          w_advance;
    logic          w_accept;
    logic          w_release;

    logic [SW-1:0] r_slot_cnt;
    logic [CW-1:0] r_match_cnt;
    logic [3:0]    r_row_pat;
    logic [3:0]    r_col;
    logic [7:0]    r_key_code;
    logic [3:0]    r_key_index;
    logic          r_key_valid;
    logic          r_key_held;

    keypad_sync u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (row),
        .o_q   (w_row_sync)
    );

    // Rows are sampled at the end of the slot so the column has settled.
    assign w_sample = (r_slot_cnt == SLOT_LAST);
    assign w_single = is_single_low(w_row_sync);
    assign w_idle   = (w_row_sync == ROW_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_SCAN;
        else        r_state <= w_state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_match_nxt = r_match_cnt;
        w_capture   = 1'b0;
        w_advance   = 1'b0;
        w_accept    = 1'b0;
        w_release   = 1'b0;
        if (w_sample) begin
            case (r_state)
                ST_SCAN: begin
                    if (w_single) begin
                        w_capture   = 1'b1;
                        w_match_nxt = CW'(1);
                        w_state_nxt = ST_DEBOUNCE;
                    end else begin
                        w_advance   = 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (w_row_sync != r_row_pat) begin
                        w_match_nxt = '0;
                        w_advance   = 1'b1;
                        w_state_nxt = ST_SCAN;
                    end else if (r_match_cnt == MATCH_LAST) begin
                        w_match_nxt = '0;
                        w_accept    = 1'b1;
                        w_state_nxt = ST_HELD;
                    end else begin
                        w_match_nxt = r_match_cnt + CW'(1);
                    end
                end
                ST_HELD: begin
                    if (w_idle) begin
                        w_match_nxt = CW'(1);
                        w_state_nxt = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!w_idle) begin
                        w_match_nxt = '0;
                        w_state_nxt = ST_HELD;
                    end else if (r_match_cnt == MATCH_LAST) begin
                        w_match_nxt = '0;
                        w_release   = 1'b1;
                        w_advance   = 1'b1;
                        w_state_nxt = ST_SCAN;
                    end else begin
                        w_match_nxt = r_match_cnt + CW'(1);
                    end
                end
                default: begin
                    w_match_nxt = '0;
                    w_state_nxt = ST_SCAN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_cnt  <= '0;
            r_match_cnt <= '0;
            r_row_pat   <= ROW_IDLE;
            r_col       <= COL_INIT;
            r_key_code  <= 8'h00;
            r_key_index <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_slot_cnt  <= w_sample ? '0 : r_slot_cnt + SW'(1);
            r_match_cnt <= w_match_nxt;
            r_key_valid <= w_accept;
            if (w_capture) r_row_pat <= w_row_sync;
            if (w_advance) r_col <= {r_col[2:0], r_col[3]};
            if (w_accept) begin
                r_key_code  <= {r_col, r_row_pat};
                r_key_index <= {low_idx(r_row_pat), low_idx(r_col)};
            end
            if (w_accept)       r_key_held <= 1'b1;
            else if (w_release) r_key_held <= 1'b0;
        end
    end

    assign col       = r_col;
    assign key_code  = r_key_code;
    assign key_index = r_key_index;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clock cycles per column slot; legal range 4 or more.
REQ-002 Parameter DEBOUNCE_CNT, default 4: consecutive matching row samples needed to accept a press or a release; legal range 2 or more.
REQ-003 Port clk, input, 1: single system clock; all state on rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port row, input, 4: keypad row lines; active-low, pulled up externally; asynchronous to clk.
REQ-006 Port col, output, 4: keypad column drive; active-low one-hot (exactly one bit 0).
REQ-007 Port key_code, output, 8: accepted key as {col, row} raw active-low nibbles; the 8-bit format the downstream HEX decoder consumes.
REQ-008 Port key_index, output, 4: {row_idx[1:0], col_idx[1:0]}, where idx = position of the low bit.
REQ-009 Port key_valid, output, 1: one-cycle pulse when a new key is accepted.
REQ-010 Port key_held, output, 1: high from acceptance until release is accepted.

Function
REQ-011 Row shall pass through a 2-flop synchronizer; all logic uses the synchronized value only.
REQ-012 Slot counter shall count 0..SCAN_DIV-1 and wrap; the row sample is taken when the count equals SCAN_DIV-1 (settling time).
REQ-013 Column sequence shall be 1110, 1101, 1011, 0111, then wrap to 1110; col advances only on the cycle after a sample in state SCAN.
REQ-014 A sample is a "single press" when exactly one row bit is 0; zero or multiple low bits count as "no key".
REQ-015 FSM states: SCAN, DEBOUNCE, HELD, RELEASE; reset state SCAN.
REQ-016 SCAN: on a single-press sample, store the row pattern, set match count to 1, go to DEBOUNCE, and freeze col; otherwise advance col.
REQ-017 DEBOUNCE: each sample equal to the stored pattern increments the count; a differing sample returns to SCAN and advances col.
REQ-018 DEBOUNCE: when the count reaches DEBOUNCE_CNT, go to HELD, latch key_code/key_index, pulse key_valid in the next cycle, and set key_held.
REQ-019 HELD: col stays frozen; the first all-high sample goes to RELEASE with count 1; any low sample (same or other row) keeps HELD.
REQ-020 RELEASE: each all-high sample increments the count; any low sample returns to HELD and resets the count.
REQ-021 RELEASE: on reaching DEBOUNCE_CNT, clear key_held, go to SCAN, and advance col; key_code/key_index keep their last value.
REQ-022 Outside the single pulse of REQ-018, key_valid shall be 0; no repeat pulses while held.
REQ-023 Keys on other columns pressed during HELD are invisible; after release, scanning resumes at the next column.
REQ-024 Counters shall saturate/clear explicitly; no wrap of the match counter.

Reset
REQ-025 When rst_n is low, all state clears asynchronously: col=1110, key_code=8'h00, key_index=0, key_valid=0, key_held=0, state SCAN, counters 0, synchronizer flops 1111.
REQ-026 Reset asserted mid-DEBOUNCE or mid-HELD shall abandon the key with no key_valid pulse; the first sample after release is a fresh SCAN.

Structure
REQ-027 A shared package shall hold the FSM state encoding, COL_INIT=4'b1110, and ROW_IDLE=4'b1111.
REQ-028 One sub-module, keypad_sync (2-flop, 4-bit, reset to 1111), shall be instantiated for row.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3)
REQ-029 No key held 40 cycles -> col cycles 1110, 1101, 1011, 0111, 1110 every 4 cycles; key_valid never asserts.
REQ-030 Row 1101 held low while col=1011 -> after 3 samples, one key_valid pulse, key_code=8'hBD, key_index=4'b0110, key_held=1.
REQ-031 Bouncy press (match, mismatch, match ...) -> no key_valid until 3 consecutive matching samples.
REQ-032 Release of the held key with one low glitch after 2 idle samples -> stays HELD; key_held clears only after 3 consecutive idle samples; col then advances.
REQ-033 Two rows low in the same column -> treated as no key; no key_valid; scanning continues.
REQ-034 rst_n pulsed low during DEBOUNCE -> outputs go to reset values immediately; no key_valid pulse afterwards.
